// File: rtl/timer_pwm_pkg.sv
// Shared definitions for the timer/PWM register block: register offsets,
// CTRL/STATUS bit positions, AXI response codes, CTRL layout and a byte-strobe merge helper.
package timer_pwm_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  // Byte offsets of the register map
  localparam int unsigned REG_CTRL   = 32'h00;
  localparam int unsigned REG_PERIOD = 32'h04;
  localparam int unsigned REG_DUTY   = 32'h08;
  localparam int unsigned REG_STATUS = 32'h0C;
  localparam int unsigned REG_ID     = 32'h10;

  // CTRL bit positions
  localparam int unsigned CTRL_ENABLE      = 0;
  localparam int unsigned CTRL_MODE_PWM    = 1;
  localparam int unsigned CTRL_IRQ_DONE_EN = 2;
  localparam int unsigned CTRL_IRQ_OVF_EN  = 3;

  // STATUS bit positions
  localparam int unsigned STAT_DONE = 0;
  localparam int unsigned STAT_OVF  = 1;
  localparam int unsigned STAT_W    = 2;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  typedef struct packed {
    logic irq_ovf_en;
    logic irq_done_en;
    logic mode_pwm;
    logic enable;
  } ctrl_t;

  // Replace only the bytes of cur whose strobe is set
  function automatic logic [DATA_W-1:0] apply_strb(input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] wdata,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = cur;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_pwm_axil_regs.sv
// AXI4-Lite register file in front of the timer/PWM core.
// Ports: clk/rst_n; AXI4-Lite slave (s_axi_*); to core: enable, mode_pwm,
// period, duty (active, double-buffered); from core: timer_done, overflow;
// irq level interrupt from sticky W1C STATUS masked by CTRL enables.
module timer_pwm_axil_regs
  import timer_pwm_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter logic [31:0] ID_VALUE = 32'h5450_0100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [STRB_W-1:0] s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              enable,
  output logic              mode_pwm,
  output logic [DATA_W-1:0] period,
  output logic [DATA_W-1:0] duty,
  input  logic              timer_done,
  input  logic              overflow,
  output logic              irq
);

  // Write channel holding registers and response
  logic              aw_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic              w_held;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              bvalid_q;
  resp_e             bresp_q;

  // Register state
  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] period_pend_q, period_pend_d;
  logic [DATA_W-1:0] duty_pend_q, duty_pend_d;
  logic [DATA_W-1:0] period_act_q, duty_act_q;
  logic [STAT_W-1:0] status_q, status_d, status_set, status_clr;
  logic              irq_q;

  // Write decode
  logic              wr_commit, wr_err;
  logic [ADDR_W-1:0] wr_addr;
  logic              sel_ctrl, sel_period, sel_duty, sel_status;

  // Read channel
  logic              rvalid_q;
  resp_e             rresp_q;
  logic [DATA_W-1:0] rdata_q, rd_data;
  resp_e             rd_resp;
  logic [ADDR_W-1:0] rd_addr;

  assign s_axi_awready = !aw_held && !bvalid_q;
  assign s_axi_wready  = !w_held && !bvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = !rvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  assign enable   = ctrl_q.enable;
  assign mode_pwm = ctrl_q.mode_pwm;
  assign period   = period_act_q;
  assign duty     = duty_act_q;
  assign irq      = irq_q;

  // Write join: AW and W are buffered independently; commit once both are present
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held   <= 1'b0;
      aw_addr_q <= '0;
      w_held    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held   <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (wr_commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? SLVERR : OKAY;
      end else if (bvalid_q && s_axi_bready) begin
        bvalid_q <= 1'b0;
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
      end
    end
  end

  // Next-state for registers; the core's pulses are OR-ed in after the W1C clear so a set wins
  always_comb begin
    wr_commit     = aw_held && w_held && !bvalid_q;
    wr_addr       = aw_addr_q & ~ADDR_W'(3);
    sel_ctrl      = (wr_addr == ADDR_W'(REG_CTRL));
    sel_period    = (wr_addr == ADDR_W'(REG_PERIOD));
    sel_duty      = (wr_addr == ADDR_W'(REG_DUTY));
    sel_status    = (wr_addr == ADDR_W'(REG_STATUS));
    wr_err        = !(sel_ctrl || sel_period || sel_duty || sel_status);
    ctrl_d        = ctrl_q;
    period_pend_d = period_pend_q;
    duty_pend_d   = duty_pend_q;
    status_clr    = '0;
    status_set    = '0;
    if (wr_commit) begin
      if (sel_ctrl && w_strb_q[0]) begin
        ctrl_d.enable      = w_data_q[CTRL_ENABLE];
        ctrl_d.mode_pwm    = w_data_q[CTRL_MODE_PWM];
        ctrl_d.irq_done_en = w_data_q[CTRL_IRQ_DONE_EN];
        ctrl_d.irq_ovf_en  = w_data_q[CTRL_IRQ_OVF_EN];
      end
      if (sel_period) period_pend_d = apply_strb(period_pend_q, w_data_q, w_strb_q);
      if (sel_duty)   duty_pend_d   = apply_strb(duty_pend_q, w_data_q, w_strb_q);
      if (sel_status && w_strb_q[0]) begin
        status_clr[STAT_DONE] = w_data_q[STAT_DONE];
        status_clr[STAT_OVF]  = w_data_q[STAT_OVF];
      end
    end
    status_set[STAT_DONE] = timer_done;
    status_set[STAT_OVF]  = overflow;
    status_d = (status_q & ~status_clr) | status_set;
  end

  // Register file, shadow transfer and interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q        <= '0;
      period_pend_q <= '0;
      duty_pend_q   <= '0;
      period_act_q  <= '0;
      duty_act_q    <= '0;
      status_q      <= '0;
      irq_q         <= 1'b0;
    end else begin
      ctrl_q        <= ctrl_d;
      period_pend_q <= period_pend_d;
      duty_pend_q   <= duty_pend_d;
      status_q      <= status_d;
      // irq tracks the registered status/enables without an extra cycle of lag
      irq_q <= (status_d[STAT_DONE] & ctrl_d.irq_done_en) |
               (status_d[STAT_OVF] & ctrl_d.irq_ovf_en);
      // Apply new period/duty only while stopped or at a cycle boundary
      if (!ctrl_q.enable || timer_done) begin
        period_act_q <= period_pend_q;
        duty_act_q   <= duty_pend_q;
      end
    end
  end

  // Read decode
  always_comb begin
    rd_addr = s_axi_araddr & ~ADDR_W'(3);
    rd_data = '0;
    rd_resp = OKAY;
    if (rd_addr == ADDR_W'(REG_CTRL))        rd_data = DATA_W'(ctrl_q);
    else if (rd_addr == ADDR_W'(REG_PERIOD)) rd_data = period_pend_q;
    else if (rd_addr == ADDR_W'(REG_DUTY))   rd_data = duty_pend_q;
    else if (rd_addr == ADDR_W'(REG_STATUS)) rd_data = DATA_W'(status_q);
    else if (rd_addr == ADDR_W'(REG_ID))     rd_data = ID_VALUE;
    else                                     rd_resp = SLVERR;
  end

  // Read channel: data captured on AR handshake and held until R handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else if (s_axi_arvalid && !rvalid_q) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_pwm_axil_regs.sv
// Self-checking bench for timer_pwm_axil_regs: directed scenarios plus a
// randomized mix of reads, writes and core pulses against a register-level model.
module tb_timer_pwm_axil_regs;

  logic        clk;
  logic        rst_n;
  logic [4:0]  s_axi_awaddr;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [4:0]  s_axi_araddr;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid, s_axi_rready;
  logic        enable, mode_pwm, irq;
  logic [31:0] period, duty;
  logic        timer_done, overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0]  m_ctrl;
  logic [31:0] m_ppend, m_dpend, m_pact, m_dact;
  logic [1:0]  m_status;

  timer_pwm_axil_regs #(.ADDR_W(5), .ID_VALUE(32'h5450_0100)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .enable(enable), .mode_pwm(mode_pwm), .period(period), .duty(duty),
    .timer_done(timer_done), .overflow(overflow), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1);
  end

  // ---------------- model ----------------
  task automatic model_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    int word;
    word = int'(addr[4:2]);
    resp = 2'b00;
    case (word)
      0: if (strb[0]) m_ctrl = data[3:0];
      1: for (int b = 0; b < 4; b++) if (strb[b]) m_ppend[b*8 +: 8] = data[b*8 +: 8];
      2: for (int b = 0; b < 4; b++) if (strb[b]) m_dpend[b*8 +: 8] = data[b*8 +: 8];
      3: if (strb[0]) m_status = m_status & ~data[1:0];
      default: resp = 2'b10;
    endcase
  endtask

  task automatic model_read(input logic [4:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
    int word;
    word = int'(addr[4:2]);
    resp = 2'b00;
    case (word)
      0: data = {28'd0, m_ctrl};
      1: data = m_ppend;
      2: data = m_dpend;
      3: data = {30'd0, m_status};
      4: data = 32'h5450_0100;
      default: begin data = 32'd0; resp = 2'b10; end
    endcase
  endtask

  function automatic logic model_irq();
    return (m_status[0] & m_ctrl[2]) | (m_status[1] & m_ctrl[3]);
  endfunction

  // Stopped timer: the core always sees the latest pending values
  task automatic model_settle();
    if (!m_ctrl[0]) begin
      m_pact = m_ppend;
      m_dact = m_dpend;
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_ppend = '0; m_dpend = '0; m_pact = '0; m_dact = '0; m_status = '0;
  endtask

  // ---------------- bus drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Write with independent AW/W delays; optional timer_done pulse on the commit cycle
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input bit pulse,
                           output logic [1:0] resp);
    bit aw_done, w_done, got, pulsed, aw_hs, w_hs;
    int cyc;
    aw_done = 0; w_done = 0; got = 0; pulsed = 0; cyc = 0; resp = 2'b11;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb; s_axi_bready = 1'b1;
    while (!got && cyc < 40) begin
      s_axi_awvalid = !aw_done && (cyc >= aw_dly);
      s_axi_wvalid  = !w_done && (cyc >= w_dly);
      @(negedge clk);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      if (s_axi_bvalid) begin
        resp = s_axi_bresp;
        got  = 1;
      end
      @(posedge clk);
      #1;
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      if (pulse && aw_done && w_done && !pulsed && !got) begin
        timer_done = 1'b1;
        pulsed = 1;
      end else begin
        timer_done = 1'b0;
      end
      cyc++;
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0; timer_done = 0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL write_timeout addr=%h: bvalid got 0, required 1", addr);
    end
  endtask

  // Read; rready is withheld rdy_dly cycles after rvalid to exercise data hold
  task automatic axi_read(input logic [4:0] addr, input int rdy_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    bit got, seen, unstable, ar_hs;
    int cyc, waited;
    got = 0; seen = 0; unstable = 0; cyc = 0; waited = 0;
    data = 32'hxxxx_xxxx; resp = 2'b11;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      ar_hs = s_axi_arvalid && s_axi_arready;
      if (s_axi_rvalid) begin
        if (!seen) begin
          data = s_axi_rdata;
          resp = s_axi_rresp;
          seen = 1;
        end else if (s_axi_rdata !== data || s_axi_rresp !== resp) begin
          unstable = 1;
        end
        if (waited >= rdy_dly) begin
          s_axi_rready = 1'b1;
          got = 1;
        end else begin
          waited++;
        end
      end
      @(posedge clk);
      #1;
      if (ar_hs) s_axi_arvalid = 1'b0;
      cyc++;
    end
    s_axi_arvalid = 0; s_axi_rready = 0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL read_timeout addr=%h: rvalid got 0, required 1", addr);
    end
    if (rdy_dly > 0) begin
      checks++;
      if (unstable) begin
        errors++;
        $display("FAIL rdata_hold addr=%h: got changing rdata/rresp, required stable %h", addr, data);
      end
    end
  endtask

  // Model-tracked write with random channel skew
  task automatic wr(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input bit pulse, output logic [1:0] resp, output logic [1:0] exp);
    if (pulse) begin
      m_pact = m_ppend;
      m_dact = m_dpend;
    end
    model_write(addr, data, strb, exp);
    if (pulse) m_status[0] = 1'b1;
    axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), pulse, resp);
    idle(2);
    model_settle();
  endtask

  task automatic pulse_core(input bit td, input bit ov);
    timer_done = td;
    overflow   = ov;
    @(posedge clk);
    #1;
    timer_done = 0;
    overflow   = 0;
    if (td) begin
      m_status[0] = 1'b1;
      m_pact = m_ppend;
      m_dact = m_dpend;
    end
    if (ov) m_status[1] = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    rst_n = 0;
    s_axi_awaddr = 0; s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wvalid = 0;
    s_axi_bready = 0; s_axi_araddr = 0; s_axi_arvalid = 0; s_axi_rready = 0;
    timer_done = 0; overflow = 0;
    model_reset();
    idle(3);
    rst_n = 1;
    idle(1);
    checks++;
    if ({s_axi_bvalid, s_axi_rvalid, irq, enable, mode_pwm} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000", {s_axi_bvalid, s_axi_rvalid, irq, enable, mode_pwm});
    end
    checks++;
    if (period !== 32'd0 || duty !== 32'd0) begin
      errors++;
      $display("FAIL reset_active: got period=%h duty=%h, required 0/0", period, duty);
    end
    checks++;
    if (s_axi_bresp !== 2'b00 || s_axi_rresp !== 2'b00) begin
      errors++;
      $display("FAIL reset_resp: got bresp=%b rresp=%b, required 00/00", s_axi_bresp, s_axi_rresp);
    end
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
    axi_read(5'h10, 0, d, r);
    checks++;
    if (d !== 32'h5450_0100 || r !== 2'b00) begin
      errors++;
      $display("FAIL read_id: got %h/%b, required 54500100/00", d, r);
    end
    axi_read(5'h00, 0, d, r);
    checks++;
    if (d !== 32'd0 || r !== 2'b00) begin
      errors++;
      $display("FAIL read_ctrl_reset: got %h/%b, required 0/00", d, r);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d;
    logic [1:0]  r;
    bit saw_b;
    s_axi_awaddr = 5'h08; s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_bready = 1;
    @(posedge clk);
    #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    rst_n = 0;
    saw_b = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      if (s_axi_bvalid) saw_b = 1;
    end
    #1;
    s_axi_bready = 0;
    checks++;
    if (saw_b) begin
      errors++;
      $display("FAIL reset_drop: got bvalid=1 after reset, required 0");
    end
    axi_read(5'h08, 0, d, r);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL reset_drop_duty: got %h, required 0", d);
    end
  endtask

  task automatic test_aw_w_skew();
    logic [1:0]  exp;
    logic [31:0] d;
    logic [1:0]  r;
    bit bad;
    s_axi_awaddr = 5'h08; s_axi_wdata = 32'hCAFE_0001; s_axi_wstrb = 4'hF; s_axi_bready = 0;
    s_axi_awvalid = 1;
    @(posedge clk);            // t0: AW handshake
    #1;
    s_axi_awvalid = 0;
    checks++;
    if (s_axi_awready !== 1'b0 || s_axi_bvalid !== 1'b0) begin
      errors++;
      $display("FAIL skew_aw_held: got awready=%b bvalid=%b, required 0/0", s_axi_awready, s_axi_bvalid);
    end
    idle(2);
    s_axi_wvalid = 1;
    @(posedge clk);            // t0+3: W handshake
    #1;
    s_axi_wvalid = 0;
    checks++;
    if (s_axi_bvalid !== 1'b0) begin
      errors++;
      $display("FAIL skew_early_b: got bvalid=%b at t0+3, required 0", s_axi_bvalid);
    end
    @(posedge clk);            // t0+4: commit
    #1;
    checks++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin
      errors++;
      $display("FAIL skew_b: got bvalid=%b bresp=%b at t0+4, required 1/00", s_axi_bvalid, s_axi_bresp);
    end
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL skew_b_hold: got bvalid/awready changing under bready=0, required 1/0");
    end
    s_axi_bready = 1;
    @(posedge clk);
    #1;
    s_axi_bready = 0;
    checks++;
    if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin
      errors++;
      $display("FAIL skew_b_release: got bvalid=%b awready=%b, required 0/1", s_axi_bvalid, s_axi_awready);
    end
    model_write(5'h08, 32'hCAFE_0001, 4'hF, exp);
    idle(2);
    model_settle();
    axi_read(5'h08, 2, d, r);
    checks++;
    if (d !== m_dpend || r !== exp) begin
      errors++;
      $display("FAIL skew_duty_readback: got %h/%b, required %h/%b", d, r, m_dpend, exp);
    end
  endtask

  task automatic test_shadow();
    logic [1:0]  resp, exp;
    logic [31:0] d;
    logic [1:0]  r;
    wr(5'h00, 32'h0, 4'hF, 0, resp, exp);
    wr(5'h04, 32'd9, 4'hF, 0, resp, exp);
    wr(5'h00, 32'h1, 4'hF, 0, resp, exp);
    checks++;
    if (period !== 32'd9 || enable !== 1'b1) begin
      errors++;
      $display("FAIL shadow_setup: got period=%0d enable=%b, required 9/1", period, enable);
    end
    wr(5'h04, 32'd4, 4'hF, 0, resp, exp);
    idle(3);
    checks++;
    if (period !== 32'd9) begin
      errors++;
      $display("FAIL shadow_hold: got period=%0d, required 9", period);
    end
    axi_read(5'h04, 0, d, r);
    checks++;
    if (d !== 32'd4) begin
      errors++;
      $display("FAIL shadow_readback: got %0d, required 4", d);
    end
    checks++;
    if (period !== 32'd9) begin
      errors++;
      $display("FAIL shadow_hold2: got period=%0d, required 9", period);
    end
    pulse_core(1, 0);
    checks++;
    if (period !== 32'd4) begin
      errors++;
      $display("FAIL shadow_apply: got period=%0d, required 4", period);
    end
    wr(5'h0C, 32'h3, 4'hF, 0, resp, exp);
  endtask

  task automatic test_status_irq();
    logic [1:0]  resp, exp;
    logic [31:0] d;
    logic [1:0]  r;
    wr(5'h00, 32'h4, 4'hF, 0, resp, exp);
    pulse_core(1, 0);
    idle(1);
    axi_read(5'h0C, 0, d, r);
    checks++;
    if (d !== 32'd1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL status_done_set: got status=%h irq=%b, required 1/1", d, irq);
    end
    wr(5'h0C, 32'h1, 4'hF, 1, resp, exp);
    axi_read(5'h0C, 0, d, r);
    checks++;
    if (d !== 32'd1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL status_set_wins: got status=%h irq=%b, required 1/1", d, irq);
    end
    wr(5'h0C, 32'h1, 4'hF, 0, resp, exp);
    axi_read(5'h0C, 0, d, r);
    checks++;
    if (d !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL status_clear: got status=%h irq=%b, required 0/0", d, irq);
    end
    pulse_core(0, 1);
    idle(1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL ovf_masked: got irq=%b, required 0", irq);
    end
    wr(5'h00, 32'h8, 4'hF, 0, resp, exp);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL ovf_irq: got irq=%b, required 1", irq);
    end
    wr(5'h0C, 32'h2, 4'hF, 0, resp, exp);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got irq=%b, required 0", irq);
    end
  endtask

  task automatic test_errors();
    logic [1:0]  resp, exp;
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    wr(5'h14, 32'hFFFF_FFFF, 4'hF, 0, resp, exp);
    checks++;
    if (resp !== 2'b10) begin
      errors++;
      $display("FAIL unmapped_write: got bresp=%b, required 10", resp);
    end
    wr(5'h10, 32'hFFFF_FFFF, 4'hF, 0, resp, exp);
    checks++;
    if (resp !== 2'b10) begin
      errors++;
      $display("FAIL id_write: got bresp=%b, required 10", resp);
    end
    for (int a = 0; a <= 16; a += 4) begin
      axi_read(5'(a), 0, d, r);
      model_read(5'(a), ed, er);
      checks++;
      if (d !== ed || r !== er) begin
        errors++;
        $display("FAIL no_change addr=%h: got %h/%b, required %h/%b", a, d, r, ed, er);
      end
    end
    axi_read(5'h1C, 3, d, r);
    checks++;
    if (d !== 32'd0 || r !== 2'b10) begin
      errors++;
      $display("FAIL unmapped_read: got %h/%b, required 0/10", d, r);
    end
  endtask

  task automatic test_wstrb();
    logic [1:0]  resp, exp;
    logic [31:0] d;
    logic [1:0]  r;
    wr(5'h08, 32'h1234_5678, 4'hF, 0, resp, exp);
    wr(5'h08, 32'h0000_AB00, 4'b0010, 0, resp, exp);
    axi_read(5'h08, 0, d, r);
    checks++;
    if (d !== 32'h1234_AB78) begin
      errors++;
      $display("FAIL wstrb_duty: got %h, required 1234ab78", d);
    end
    checks++;
    if (duty !== 32'h1234_AB78) begin
      errors++;
      $display("FAIL wstrb_duty_active: got %h, required 1234ab78", duty);
    end
  endtask

  task automatic test_random();
    logic [4:0]  a;
    logic [31:0] d, ed;
    logic [1:0]  r, er, resp, exp;
    int op;
    for (int i = 0; i < 120; i++) begin
      op = int'($urandom_range(0, 4));
      a  = 5'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      if (op <= 1) begin
        wr(a, $urandom, 4'($urandom_range(0, 15)), 0, resp, exp);
        checks++;
        if (resp !== exp) begin
          errors++;
          $display("FAIL rand_bresp i=%0d addr=%h: got %b, required %b", i, a, resp, exp);
        end
      end else if (op <= 3) begin
        model_read(a, ed, er);
        axi_read(a, $urandom_range(0, 2), d, r);
        checks++;
        if (d !== ed || r !== er) begin
          errors++;
          $display("FAIL rand_read i=%0d addr=%h: got %h/%b, required %h/%b", i, a, d, r, ed, er);
        end
      end else begin
        pulse_core(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle(2);
        model_settle();
      end
      checks++;
      if (period !== m_pact || duty !== m_dact) begin
        errors++;
        $display("FAIL rand_active i=%0d: got %h/%h, required %h/%h", i, period, duty, m_pact, m_dact);
      end
      checks++;
      if ({mode_pwm, enable} !== m_ctrl[1:0]) begin
        errors++;
        $display("FAIL rand_ctrl_out i=%0d: got %b, required %b", i, {mode_pwm, enable}, m_ctrl[1:0]);
      end
      checks++;
      if (irq !== model_irq()) begin
        errors++;
        $display("FAIL rand_irq i=%0d: got %b, required %b", i, irq, model_irq());
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_midflight();
    test_aw_w_skew();
    test_shadow();
    test_status_irq();
    test_errors();
    test_wstrb();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
